// File: rtl/cohort_mem_pkg.sv
// Shared types and helpers for the cohort load-request responder.
// Widths here are the defaults for the responder; mem_resp_t is sized from them.
package cohort_mem_pkg;

  localparam int CM_ADDR_W     = 64;
  localparam int CM_DATA_W     = 64;
  localparam int CM_TAG_W      = 4;
  localparam int CM_MEM_WORDS  = 1024;
  localparam int CM_RD_LAT     = 2;
  localparam int CM_RESP_DEPTH = 4;

  typedef struct packed {
    logic [CM_DATA_W-1:0] data;
    logic [CM_TAG_W-1:0]  tag;
    logic                 err;
  } mem_resp_t;

  // True when the word index of a byte address falls inside the backing SRAM.
  function automatic logic addr_in_range(input logic [CM_ADDR_W-1:0] addr,
                                         input int unsigned          off_w,
                                         input int unsigned          words);
    return (addr >> off_w) < CM_ADDR_W'(words);
  endfunction

endpackage

// File: rtl/cohort_mem_responder_if.sv
// Request/response/SRAM signal bundle between mem_controller, the responder and its scratch SRAM.
interface cohort_mem_responder_if #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4,
  parameter int MEM_WORDS = 1024
);
  localparam int MEM_AW = $clog2(MEM_WORDS);

  // Handshakes: a beat transfers on a cycle where valid & ready are both 1; the sender holds
  // valid and its payload stable until that cycle, and ready may not depend on that cycle's valid.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;

  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  req_valid, req_addr, req_tag, resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_data, resp_tag, resp_err, mem_rd_en, mem_rd_addr
  );

  modport master (
    output req_valid, req_addr, req_tag, resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_err, mem_rd_en, mem_rd_addr
  );

endinterface

// File: rtl/cohort_sync_fifo.sv
// Synchronous FIFO with register-array storage; head entry is read straight from a flop.
// DEPTH must be a power of two so the pointers wrap naturally.
module cohort_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cohort_mem_responder.sv
// Responder for in-order cohort load requests: fixed-latency SRAM read, errored requests bypass
// the SRAM but ride the same pipe so responses stay in request order.
module cohort_mem_responder
  import cohort_mem_pkg::*;
#(
  parameter int ADDR_W     = CM_ADDR_W,
  parameter int DATA_W     = CM_DATA_W,
  parameter int TAG_W      = CM_TAG_W,
  parameter int MEM_WORDS  = CM_MEM_WORDS,
  parameter int RD_LAT     = CM_RD_LAT,
  parameter int RESP_DEPTH = CM_RESP_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  cohort_mem_responder_if.slave bus
);
  localparam int OFF_W  = $clog2(DATA_W/8);
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int CRED_W = $clog2(RESP_DEPTH+1);
  localparam int RESP_W = $bits(mem_resp_t);

  logic                         fire, pop, req_err, push;
  logic [CRED_W-1:0]            credits_q, credits_d;
  logic [RD_LAT-1:0]            pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]            pipe_err_q, pipe_err_d;
  logic [RD_LAT-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
  mem_resp_t                    push_entry, head_entry;
  logic                         fifo_full, fifo_empty;
  logic [CRED_W-1:0]            fifo_count;
  logic                         unused_fifo_status;

  // Credits count free response slots, so a push at the pipe tail can never find the FIFO full.
  assign bus.req_ready = (credits_q != '0) & ~rst;
  assign fire          = bus.req_valid & bus.req_ready;
  assign pop           = bus.resp_valid & bus.resp_ready;
  assign req_err       = (bus.req_addr[OFF_W-1:0] != '0) |
                         ~addr_in_range(CM_ADDR_W'(bus.req_addr), OFF_W, MEM_WORDS);

  assign bus.mem_rd_en   = fire & ~req_err;
  assign bus.mem_rd_addr = bus.req_addr[OFF_W +: MEM_AW];

  always_comb begin
    credits_d = credits_q;
    if (fire && !pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!fire && pop) begin
      credits_d = credits_q + CRED_W'(1);
    end
  end

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_err_d    = pipe_err_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_vld_d[0] = fire;
    pipe_err_d[0] = req_err;
    pipe_tag_d[0] = bus.req_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q  <= CRED_W'(RESP_DEPTH);
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      credits_q  <= credits_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  // The last pipe stage lines up with the SRAM data returning for the same request.
  always_comb begin
    push            = pipe_vld_q[RD_LAT-1];
    push_entry      = '0;
    push_entry.err  = pipe_err_q[RD_LAT-1];
    push_entry.tag  = pipe_tag_q[RD_LAT-1];
    push_entry.data = pipe_err_q[RD_LAT-1] ? '0 : bus.mem_rd_data;
  end

  cohort_sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_fifo_status = &{1'b0, fifo_full, fifo_count};

  assign bus.resp_valid = ~fifo_empty;
  assign bus.resp_data  = fifo_empty ? '0 : head_entry.data;
  assign bus.resp_tag   = fifo_empty ? '0 : head_entry.tag;
  assign bus.resp_err   = fifo_empty ? 1'b0 : head_entry.err;

endmodule
